// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core: stall/clear controls, EX operand
// forwarding selects, and a timed wait state for multi-cycle data-memory accesses.
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic             useRs1D,
    input  logic             useRs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic             RegWEnE,
    input  logic [1:0]       WBselE,
    input  logic             pcSelE,
    input  logic [4:0]       rdM,
    input  logic             RegWEnM,
    input  logic             memValidM,
    input  logic             memReady,
    input  logic [4:0]       rdW,
    input  logic             RegWEnW,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             clearD,
    output logic             clearE,
    output logic             clearM,
    output logic             clearW,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             memErr,
    output logic [CNT_W-1:0] stallCount
);

    localparam int              WC_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  waitCnt_q, waitCnt_d;
    logic             memErr_q, memErr_d;
    logic [CNT_W-1:0] stallCount_q, stallCount_d;
    logic             loadE;
    logic             loadUse;
    logic             runCtrl;

    // MEM-stage result is younger than WB, so it wins; x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wenM,
                                           input logic [4:0] dM,
                                           input logic       wenW,
                                           input logic [4:0] dW);
        if (wenM && dM != 5'd0 && dM == rs)
            return 2'd1;
        else if (wenW && dW != 5'd0 && dW == rs)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        memErr_d  = memErr_q;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        clearD    = 1'b0;
        clearE    = 1'b0;
        clearM    = 1'b0;
        clearW    = 1'b0;
        runCtrl   = 1'b0;

        loadE   = RegWEnE && (WBselE == 2'd0) && (rdE != 5'd0);
        loadUse = loadE && ((useRs1D && rs1D == rdE) || (useRs2D && rs2D == rdE));

        unique case (state_q)
            RUN: begin
                if (memValidM && !memReady) begin
                    {stallF, stallD, stallE, stallM, clearW} = 5'b11111;
                    state_d   = MEM_WAIT;
                    waitCnt_d = WC_W'(1);
                end else begin
                    runCtrl = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (memReady) begin
                    state_d   = RUN;
                    waitCnt_d = '0;
                    runCtrl   = 1'b1;
                end else if (waitCnt_q == WC_LAST) begin
                    // Abandon the access: the EX/MEM contents are dropped and the error latched.
                    clearM    = 1'b1;
                    memErr_d  = 1'b1;
                    state_d   = RUN;
                    waitCnt_d = '0;
                    runCtrl   = 1'b1;
                end else begin
                    {stallF, stallD, stallE, stallM, clearW} = 5'b11111;
                    waitCnt_d = waitCnt_q + WC_W'(1);
                end
            end
            default: begin
                state_d   = RUN;
                waitCnt_d = '0;
            end
        endcase

        // A taken branch squashes the dependent decode instruction, so it overrides load-use.
        if (runCtrl) begin
            if (pcSelE) begin
                clearD = 1'b1;
                clearE = 1'b1;
            end else if (loadUse) begin
                stallF = 1'b1;
                stallD = 1'b1;
                clearE = 1'b1;
            end
        end

        fwdA = fwd_sel(rs1E, RegWEnM, rdM, RegWEnW, rdW);
        fwdB = fwd_sel(rs2E, RegWEnM, rdM, RegWEnW, rdW);

        if (rst) begin
            {stallF, stallD, stallE, stallM} = 4'b0000;
            {clearD, clearE, clearM, clearW} = 4'b1111;
            fwdA = 2'd0;
            fwdB = 2'd0;
        end

        stallCount_d = stallCount_q + CNT_W'(stallF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            waitCnt_q    <= '0;
            memErr_q     <= 1'b0;
            stallCount_q <= '0;
        end else begin
            state_q      <= state_d;
            waitCnt_q    <= waitCnt_d;
            memErr_q     <= memErr_d;
            stallCount_q <= stallCount_d;
        end
    end

    assign memErr     = memErr_q;
    assign stallCount = stallCount_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle expectations are queued as stimulus is
// applied and popped for comparison on the following falling edge.
module tb_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic          useRs1D, useRs2D, RegWEnE, pcSelE, RegWEnM, memValidM, memReady, RegWEnW;
    logic [1:0]    WBselE;
    logic          stallF, stallD, stallE, stallM, clearD, clearE, clearM, clearW;
    logic [1:0]    fwdA, fwdB;
    logic          memErr;
    logic [CW-1:0] stallCount;

    typedef struct {
        logic [7:0]  ctrl;
        logic [3:0]  fwd;
        logic        err;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .RegWEnE(RegWEnE), .WBselE(WBselE),
        .pcSelE(pcSelE), .rdM(rdM), .RegWEnM(RegWEnM), .memValidM(memValidM),
        .memReady(memReady), .rdW(rdW), .RegWEnW(RegWEnW),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .clearD(clearD), .clearE(clearE), .clearM(clearM), .clearW(clearW),
        .fwdA(fwdA), .fwdB(fwdB), .memErr(memErr), .stallCount(stallCount)
    );

    task automatic zero_in();
        rs1D = 0; rs2D = 0; useRs1D = 0; useRs2D = 0;
        rs1E = 0; rs2E = 0; rdE = 0; RegWEnE = 0; WBselE = 2'd1; pcSelE = 0;
        rdM = 0; RegWEnM = 0; memValidM = 0; memReady = 0;
        rdW = 0; RegWEnW = 0;
    endtask

    task automatic check_out();
        exp_t       e;
        logic [7:0] obs;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard: observed empty queue, expected one entry");
            return;
        end
        e   = sb.pop_front();
        obs = {stallF, stallD, stallE, stallM, clearD, clearE, clearM, clearW};
        assert (obs === e.ctrl) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s ctrl: observed %b expected %b", e.tag, obs, e.ctrl);
        end
        n_checks++;
        assert ({fwdA, fwdB} === e.fwd) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s fwd: observed %b expected %b", e.tag, {fwdA, fwdB}, e.fwd);
        end
        n_checks++;
        assert (memErr === e.err) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s memErr: observed %b expected %b", e.tag, memErr, e.err);
        end
        n_checks++;
        assert (stallCount === e.cnt) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s stallCount: observed %0d expected %0d", e.tag, stallCount, e.cnt);
        end
    endtask

    // ctrl order: {stallF, stallD, stallE, stallM, clearD, clearE, clearM, clearW}; fwd = {fwdA, fwdB}
    task automatic step(input logic [7:0] ctrl, input logic [3:0] fwd, input logic err,
                        input string tag);
        exp_t e;
        e.ctrl = ctrl; e.fwd = fwd; e.err = err; e.cnt = exp_cnt; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        check_out();
        if (rst) exp_cnt = 0;
        else if (ctrl[7]) exp_cnt = exp_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        zero_in();
        @(posedge clk);
        #1;
        step(8'b0000_1111, 4'b0000, 1'b0, "reset0");
        step(8'b0000_1111, 4'b0000, 1'b0, "reset1");
        rst = 1'b0;
        step(8'b0000_0000, 4'b0000, 1'b0, "idle");

        // load-use via rs1, then the bubble
        RegWEnE = 1; WBselE = 2'd0; rdE = 5; rs1D = 5; useRs1D = 1;
        step(8'b1100_0100, 4'b0000, 1'b0, "lu_rs1");
        zero_in();
        step(8'b0000_0000, 4'b0000, 1'b0, "lu_after");
        // x0 destination never hazards
        RegWEnE = 1; WBselE = 2'd0; rdE = 0; rs1D = 0; useRs1D = 1;
        step(8'b0000_0000, 4'b0000, 1'b0, "lu_x0");
        // rs2 path
        zero_in(); RegWEnE = 1; WBselE = 2'd0; rdE = 9; rs2D = 9; useRs2D = 1;
        step(8'b1100_0100, 4'b0000, 1'b0, "lu_rs2");
        // operand not read
        useRs2D = 0;
        step(8'b0000_0000, 4'b0000, 1'b0, "lu_unused");
        // ALU result, not a load
        useRs2D = 1; WBselE = 2'd1;
        step(8'b0000_0000, 4'b0000, 1'b0, "lu_alu");
        // branch beats load-use
        zero_in(); RegWEnE = 1; WBselE = 2'd0; rdE = 5; rs1D = 5; useRs1D = 1; pcSelE = 1;
        step(8'b0000_1100, 4'b0000, 1'b0, "br_lu");
        zero_in(); pcSelE = 1;
        step(8'b0000_1100, 4'b0000, 1'b0, "br_only");

        // single-cycle memory access
        zero_in(); memValidM = 1; memReady = 1;
        step(8'b0000_0000, 4'b0000, 1'b0, "mem_1cyc");
        // three waiting cycles, released on the fourth; forwarding stays live
        memReady = 0;
        step(8'b1111_0001, 4'b0000, 1'b0, "mw_0");
        rs1E = 7; rdW = 7; RegWEnW = 1;
        step(8'b1111_0001, 4'b1000, 1'b0, "mw_1");
        step(8'b1111_0001, 4'b1000, 1'b0, "mw_2");
        memReady = 1; rdW = 0; RegWEnW = 0; rs1E = 0;
        step(8'b0000_0000, 4'b0000, 1'b0, "mw_rel");
        zero_in();
        step(8'b0000_0000, 4'b0000, 1'b0, "mw_after");
        // memory stall wins over a branch on entry
        memValidM = 1; pcSelE = 1;
        step(8'b1111_0001, 4'b0000, 1'b0, "mw_br");
        pcSelE = 0; memReady = 1;
        step(8'b0000_0000, 4'b0000, 1'b0, "mw_br_rel");

        // timeout: three stalls, then the access is dropped and memErr latches
        zero_in(); memValidM = 1;
        step(8'b1111_0001, 4'b0000, 1'b0, "to_0");
        step(8'b1111_0001, 4'b0000, 1'b0, "to_1");
        step(8'b1111_0001, 4'b0000, 1'b0, "to_2");
        step(8'b0000_0010, 4'b0000, 1'b0, "to_drop");
        zero_in();
        step(8'b0000_0000, 4'b0000, 1'b1, "to_sticky0");
        step(8'b0000_0000, 4'b0000, 1'b1, "to_sticky1");

        // forwarding
        rs1E = 7; RegWEnM = 1; rdM = 7; RegWEnW = 1; rdW = 7;
        step(8'b0000_0000, 4'b0100, 1'b1, "fwd_mem");
        RegWEnM = 0;
        step(8'b0000_0000, 4'b1000, 1'b1, "fwd_wb");
        RegWEnM = 1; rs2E = 7;
        step(8'b0000_0000, 4'b0101, 1'b1, "fwd_both");
        rs1E = 0; rs2E = 0; rdM = 0; rdW = 0;
        step(8'b0000_0000, 4'b0000, 1'b1, "fwd_x0");
        rs1E = 4; rs2E = 3; rdM = 3; rdW = 3;
        step(8'b0000_0000, 4'b0001, 1'b1, "fwd_b_mem");
        rs1E = 4; rs2E = 6; rdM = 3; rdW = 6;
        step(8'b0000_0000, 4'b0010, 1'b1, "fwd_b_wb");

        // reset in the middle of a wait clears counters, state and memErr
        zero_in(); memValidM = 1;
        step(8'b1111_0001, 4'b0000, 1'b1, "rw_0");
        step(8'b1111_0001, 4'b0000, 1'b1, "rw_1");
        rst = 1'b1;
        step(8'b0000_1111, 4'b0000, 1'b1, "rw_rst");
        rst = 1'b0;
        step(8'b1111_0001, 4'b0000, 1'b0, "rw_a0");
        step(8'b1111_0001, 4'b0000, 1'b0, "rw_a1");
        step(8'b1111_0001, 4'b0000, 1'b0, "rw_a2");
        step(8'b0000_0010, 4'b0000, 1'b0, "rw_drop");
        zero_in();
        step(8'b0000_0000, 4'b0000, 1'b1, "rw_err");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32 core. Generates stall (hold) and clear (bubble) controls for the F/D/E/M/W pipeline registers, and forwarding selects for the EX operands. Sequences multi-cycle data-memory accesses through a wait FSM with a timeout. The clearM output drives the clear input of the EX/MEM register.

Parameters:
TIMEOUT, 16, max consecutive MEM_WAIT cycles before the memory access is abandoned and memErr is raised
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
rs1D  in  5  rs1 of instruction in decode
rs2D  in  5  rs2 of instruction in decode
useRs1D  in  1  decode instruction reads rs1
useRs2D  in  1  decode instruction reads rs2
rs1E  in  5  rs1 of instruction in execute
rs2E  in  5  rs2 of instruction in execute
rdE  in  5  destination of execute instruction
RegWEnE  in  1  execute instruction writes register
WBselE  in  2  writeback select of execute instruction (0=DMEM, 1=ALU, 2=PC+4)
pcSelE  in  1  branch/jump taken, resolved in execute
rdM  in  5  destination in memory stage
RegWEnM  in  1  memory-stage register write
memValidM  in  1  memory stage holds a load/store
memReady  in  1  data memory completes access this cycle
rdW  in  5  destination in writeback stage
RegWEnW  in  1  writeback-stage register write
stallF, stallD, stallE, stallM  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM registers
clearD, clearE, clearM, clearW  out  1 each  bubble into IF-ID / ID-EX / EX-MEM / MEM-WB
fwdA, fwdB  out  2 each  EX operand source: 0=regfile, 1=MEM-stage ALU result, 2=WB value
memErr  out  1  sticky: memory access timed out
stallCount  out  CNT_W  count of cycles with stallF=1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- While rst=1: all stall*=0; clearD/E/M/W=1; fwdA=fwdB=0. On the next edge: state=RUN, waitCnt=0, memErr=0, stallCount=0.
- FSM states: RUN, MEM_WAIT. Control outputs are combinational from state and inputs. waitCnt, memErr and stallCount are registered.
- RUN, memValidM=1 and memReady=0:
  - same cycle: stallF/D/E/M=1, clearW=1.
  - next state MEM_WAIT, waitCnt<=1.
- RUN, memValidM=1 and memReady=1: single-cycle access, no stall.
- MEM_WAIT:
  - every cycle: stallF/D/E/M=1, clearW=1. Branch and load-use logic are masked.
  - memReady=1: release the stalls this cycle (outputs as RUN), next state RUN, waitCnt<=0.
  - memReady=0 and waitCnt==TIMEOUT-1: release the stalls this cycle, clearM=1 (drop the access), memErr<=1, next RUN.
  - otherwise: waitCnt<=waitCnt+1.
- Load-use, RUN only: loadE = RegWEnE & (WBselE==0) & (rdE!=0). Hazard when loadE & ((useRs1D & rs1D==rdE) | (useRs2D & rs2D==rdE)).
  - response: stallF=1, stallD=1, clearE=1, exactly one cycle per occurrence.
- Branch, RUN only: pcSelE=1 gives clearD=1 and clearE=1, no stalls. If load-use occurs in the same cycle, the branch wins: stallF=stallD=0, because the dependent decode instruction is squashed.
- Simultaneous MEM_WAIT entry and branch: memory stall wins. pcSelE is re-sampled once the stall releases, because the E register is held.
- Forwarding, fwdA (fwdB identical using rs2E):
  - 1 if RegWEnM & rdM!=0 & rdM==rs1E.
  - else 2 if RegWEnW & rdW!=0 & rdW==rs1E.
  - else 0.
  - MEM match has priority. Forwarding is not gated by the FSM.
- x0 never causes a hazard or a forward.
- stallCount increments on every cycle where stallF=1 and rst=0. It wraps modulo 2^CNT_W.
- memErr clears only on rst.
- Reset mid-MEM_WAIT: the next state is RUN and all counters are cleared.

Test Plan:
- Reset: rst=1 for 2 cycles, all other inputs 0 -> clearD/E/M/W=1, stalls=0 while rst is high. After release: all outputs 0, stallCount=0.
- Load-use: WBselE=0, RegWEnE=1, rdE=5, rs1D=5, useRs1D=1 -> one cycle of stallF=stallD=clearE=1, stallCount=1. Repeat with rdE=0 -> no stall.
- Branch vs load-use: same stimulus plus pcSelE=1 -> clearD=clearE=1, stallF=0, stallD=0.
- Memory wait: memValidM=1, memReady low for 3 cycles then high -> stallF/D/E/M=1 and clearW=1 for 3 cycles, released on the 4th cycle, stallCount=3.
- Timeout: TIMEOUT=4, memValidM=1, memReady=0 held -> 3 stalled cycles, then on the 4th cycle clearM=1, stalls=0 and memErr=1 (sticky) from the next cycle. A later rst clears memErr.
- Forwarding: rs1E=7, RegWEnM=1, rdM=7, RegWEnW=1, rdW=7 -> fwdA=1. Drop RegWEnM -> fwdA=2. rs2E=0 with rdW=0 -> fwdB=0.
